wave_dac_tx: RTL and testbench
==============================

Name: wave_dac_tx

Overview:
- Downstream consumer of the 8-bit address generator output.
- Captures the current address once per frame and maps it through a built-in 256-entry waveform table (addr[7] selects the waveform, addr[6:0] the phase).
- Shifts the resulting 8-bit sample to an external serial DAC as a 16-bit word with chip-select framing.
- Also presents the sample in parallel for LED/scope debug.

Parameters:
- FRAME_CYC, 64, m_clk cycles per frame period; legal range 36..1023.
- CTRL, 4'b0011, 4-bit control nibble sent ahead of every sample.

Ports:
- m_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  frame-start enable.
- addr_in  input  8  address from the address generator. Changes on the falling edge of m_clk; sampled here on the rising edge.
- data_out  output  8  last looked-up sample.
- dac_sclk  output  1  serial clock to the DAC, m_clk/2 while shifting.
- dac_sync_n  output  1  active-low frame select.
- dac_din  output  1  serial data, MSB first.
- busy  output  1  high from capture until the last bit is done.
- frame_done  output  1  one-cycle pulse after each completed word.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Timer goes to 0 and the FSM to IDLE.
  - Outputs: data_out=0, dac_sclk=0, dac_sync_n=1, dac_din=0, busy=0, frame_done=0.
  - Reset mid-frame aborts the word; dac_sync_n is high on the following edge.
- Frame timer:
  - Counts 0..FRAME_CYC-1 and wraps to 0.
  - While en=0 in IDLE, the timer is held at 0.
  - The timer free-runs while a frame is in flight, regardless of en.
- FSM states: IDLE, CAPTURE, LOOKUP, SHIFT, DONE.
  - IDLE -> CAPTURE at the edge where timer==0 and en=1 (call this cycle T). addr_q <= addr_in; busy=1.
  - CAPTURE -> LOOKUP at T+1: sample_q <= table(addr_q); data_out <= table(addr_q).
  - LOOKUP -> SHIFT at T+2:
    - word = {CTRL, sample_q, 4'b0000}, 16 bits.
    - dac_sync_n=0; dac_din=word[15].
  - SHIFT lasts 32 cycles: 2 per bit.
    - Phase 0: dac_sclk=0; dac_din updates to the next bit.
    - Phase 1: dac_sclk=1; the DAC samples on the rising edge of dac_sclk.
    - A 4-bit bit counter runs 15 down to 0.
  - SHIFT -> DONE after bit 0, phase 1 (edge T+34):
    - dac_sync_n=1, dac_sclk=0, dac_din=0.
    - frame_done=1 for exactly one cycle; busy=0 in the same cycle.
  - DONE -> IDLE on the next edge.
  - The next capture occurs when the timer next equals 0.
- Table function (a = addr[6:0]):
  - addr[7]=0, triangle: a<64 -> 4*a; else -> 4*(127-a). Values: 0->0, 63->252, 64->252, 127->0.
  - addr[7]=1, square: a<64 -> 8'hFF; else -> 8'h00.
  - Table is pure combinational from addr_q; its result is registered at LOOKUP (1-cycle latency).
- Boundary conditions:
  - en dropping mid-frame does not truncate the word.
  - addr_in changing during a frame has no effect until the next capture.
  - data_out holds its value between frames.
  - en=1 with timer!=0 waits for the wrap.
  - FRAME_CYC>=36 guarantees DONE precedes the next capture.

Test Plan:
1. Reset held 3 cycles, then released with en=0 -> all outputs at reset values; no dac_sync_n activity for 200 cycles.
2. en=1, addr_in=8'h10 at capture -> data_out=8'h40 at T+2; serial word 0x3400 (0011_0100_0000_0000) on din at 16 sclk rises; sync_n low for exactly 32 cycles; frame_done at T+34.
3. addr_in sequence 8'h3F, 8'h40, 8'h7F over successive frames -> data_out 252, 252, 0. Then 8'hBF, 8'hC0 -> 8'hFF, 8'h00.
4. FRAME_CYC=64 with en held high -> frame_done pulses exactly 64 cycles apart; busy duty is 34/64.
5. en deasserted at T+10 -> current word completes (16 sclk pulses) and frame_done pulses; no further capture while en=0.
6. reset asserted at T+20 -> next edge shows sync_n=1, sclk=0, busy=0, data_out=0; a fresh frame starts at the first timer==0 with en=1 after release.

Source files
------------

// File: rtl/wave_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : wave_dac_tx
// Description : Per-frame address capture, waveform table lookup and 16-bit
//               serial DAC transmitter with parallel debug output.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_dac_tx #(
  parameter int         FRAME_CYC = 64,
  parameter logic [3:0] CTRL      = 4'b0011
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] addr_in,
  output logic [7:0] data_out,
  output logic       dac_sclk,
  output logic       dac_sync_n,
  output logic       dac_din,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_CAPTURE = 3'd1;
  localparam logic [2:0] c_LOOKUP  = 3'd2;
  localparam logic [2:0] c_SHIFT   = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  localparam logic [9:0] c_TIMER_MAX = 10'(FRAME_CYC - 1);

  logic [2:0]  r_state;
  logic [9:0]  r_timer;
  logic [7:0]  r_addr_q;
  logic [7:0]  r_sample_q;
  logic [15:0] r_word;
  logic [3:0]  r_bit_cnt;
  logic        r_phase;

  logic [6:0]  w_idx;
  logic [6:0]  w_fall;
  logic [7:0]  w_table;

  // addr[7] picks triangle (0) or square (1); addr[6] splits each into halves
  always_comb begin
    w_idx   = r_addr_q[6:0];
    w_fall  = 7'd127 - w_idx;
    w_table = 8'h00;
    if (r_addr_q[7]) begin
      w_table = w_idx[6] ? 8'h00 : 8'hFF;
    end else if (!w_idx[6]) begin
      w_table = {w_idx[5:0], 2'b00};
    end else begin
      w_table = {w_fall[5:0], 2'b00};
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if ((r_state == c_IDLE) && !en) begin
      r_timer <= '0;
    end else if (r_timer == c_TIMER_MAX) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 10'd1;
    end
  end

  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_addr_q   <= '0;
      r_sample_q <= '0;
      r_word     <= '0;
      r_bit_cnt  <= '0;
      r_phase    <= 1'b0;
      data_out   <= '0;
      dac_sclk   <= 1'b0;
      dac_sync_n <= 1'b1;
      dac_din    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (en && (r_timer == 10'd0)) begin
            r_addr_q <= addr_in;
            busy     <= 1'b1;
            r_state  <= c_CAPTURE;
          end
        end
        c_CAPTURE: begin
          r_sample_q <= w_table;
          data_out   <= w_table;
          r_state    <= c_LOOKUP;
        end
        c_LOOKUP: begin
          r_word     <= {CTRL, r_sample_q, 4'b0000};
          dac_sync_n <= 1'b0;
          dac_sclk   <= 1'b0;
          dac_din    <= CTRL[3];
          r_bit_cnt  <= 4'd15;
          r_phase    <= 1'b0;
          r_state    <= c_SHIFT;
        end
        c_SHIFT: begin
          if (!r_phase) begin
            dac_sclk <= 1'b1;
            r_phase  <= 1'b1;
          end else if (r_bit_cnt == 4'd0) begin
            dac_sync_n <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_din    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            r_phase    <= 1'b0;
            r_state    <= c_DONE;
          end else begin
            // Next bit goes out with sclk low so it is settled before the rise
            dac_sclk  <= 1'b0;
            dac_din   <= r_word[r_bit_cnt - 4'd1];
            r_bit_cnt <= r_bit_cnt - 4'd1;
            r_phase   <= 1'b0;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_dac_tx
// Description : Scoreboard bench for wave_dac_tx serial and parallel outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_dac_tx;

  logic       m_clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] addr_in = 8'h00;
  logic [7:0] data_out;
  logic       dac_sclk, dac_sync_n, dac_din, busy, frame_done;

  wave_dac_tx #(.FRAME_CYC(64), .CTRL(4'b0011)) dut (
    .m_clk(m_clk), .reset(reset), .en(en), .addr_in(addr_in),
    .data_out(data_out), .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n),
    .dac_din(dac_din), .busy(busy), .frame_done(frame_done)
  );

  always #5 m_clk = ~m_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge m_clk) cyc <= cyc + 1;

  logic [15:0] mon_word = '0, last_word = '0;
  int mon_bits = 0, mon_sync = 0, mon_busy = 0;
  int last_bits = 0, last_sync = 0, last_busy = 0;
  int done_cnt = 0, done_cyc = 0, fd_wide = 0;
  logic [7:0] last_data = '0;
  logic prev_sclk = 1'b0, prev_fd = 1'b0;

  // Reassemble the serial word from sclk rising edges seen inside the frame
  always @(negedge m_clk) begin
    if (reset) begin
      mon_word = '0; mon_bits = 0; mon_sync = 0; mon_busy = 0;
    end else begin
      if (!dac_sync_n) mon_sync++;
      if (busy) mon_busy++;
      if (dac_sclk && !prev_sclk && !dac_sync_n) begin
        mon_word = {mon_word[14:0], dac_din};
        mon_bits++;
      end
      if (frame_done && prev_fd) fd_wide++;
      if (frame_done) begin
        last_word = mon_word; last_bits = mon_bits; last_sync = mon_sync;
        last_busy = mon_busy; last_data = data_out; done_cyc = cyc;
        done_cnt++;
        mon_word = '0; mon_bits = 0; mon_sync = 0; mon_busy = 0;
      end
    end
    prev_sclk = dac_sclk;
    prev_fd = frame_done;
  end

  function automatic logic [7:0] model_sample(input logic [7:0] a);
    int p;
    p = int'(a) % 128;
    if (int'(a) >= 128) return (p < 64) ? 8'hFF : 8'h00;
    if (p < 64) return 8'(p * 4);
    return 8'(4 * (127 - p));
  endfunction

  task automatic wait_frame(output bit ok);
    int start;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge m_clk); #1;
      if (done_cnt != start) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL frame_timeout: got no frame_done, want one within 200 cycles"); end
  endtask

  task automatic test_reset();
    int act_cnt;
    reset = 1'b1; en = 1'b0; addr_in = 8'h55;
    repeat (3) @(posedge m_clk);
    #1; reset = 1'b0;
    total++;
    if ({data_out, dac_sclk, dac_sync_n, dac_din, busy, frame_done} !== 13'b0000_0000_0_1_0_0_0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b",
               {data_out, dac_sclk, dac_sync_n, dac_din, busy, frame_done}, 13'b0000_0000_0_1_0_0_0);
    end
    act_cnt = 0;
    repeat (200) begin
      @(posedge m_clk); #1;
      if (dac_sync_n !== 1'b1 || busy !== 1'b0) act_cnt++;
    end
    total++;
    if (act_cnt != 0) begin bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", act_cnt); end
  endtask

  task automatic test_first_frame();
    int c_t;
    bit ok;
    logic [7:0] exp;
    en = 1'b1; addr_in = 8'h10;
    exp_q.push_back(model_sample(8'h10));
    @(posedge m_clk); #1;
    c_t = cyc;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL capture_busy: got %b want 1", busy); end
    @(posedge m_clk); #1;
    total++;
    if (data_out !== 8'h40) begin bad++; $display("FAIL lookup_data: got %h want 40", data_out); end
    wait_frame(ok);
    exp = exp_q.pop_front();
    total++;
    if (last_word !== {4'b0011, exp, 4'b0000} || last_word !== 16'h3400) begin
      bad++; $display("FAIL first_word: got %h want 3400", last_word);
    end
    total++;
    if (last_bits != 16) begin bad++; $display("FAIL first_bits: got %0d want 16", last_bits); end
    total++;
    if (last_sync != 32) begin bad++; $display("FAIL sync_width: got %0d want 32", last_sync); end
    total++;
    if (done_cyc - c_t != 34) begin bad++; $display("FAIL done_latency: got %0d want 34", done_cyc - c_t); end
  endtask

  task automatic test_table();
    logic [7:0] addrs[5];
    logic [7:0] exp;
    bit ok;
    addrs = '{8'h3F, 8'h40, 8'h7F, 8'hBF, 8'hC0};
    foreach (addrs[i]) begin
      addr_in = addrs[i];
      exp_q.push_back(model_sample(addrs[i]));
      wait_frame(ok);
      exp = exp_q.pop_front();
      total++;
      if (last_data !== exp) begin bad++; $display("FAIL table_%h: got %h want %h", addrs[i], last_data, exp); end
      total++;
      if (last_word !== {4'b0011, exp, 4'b0000}) begin
        bad++; $display("FAIL word_%h: got %h want %h", addrs[i], last_word, {4'b0011, exp, 4'b0000});
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    bit ok;
    logic [7:0] exp;
    for (int k = 0; k < 3; k++) begin
      prev = done_cyc;
      exp_q.push_back(model_sample(addr_in));
      wait_frame(ok);
      exp = exp_q.pop_front();
      total++;
      if (done_cyc - prev != 64) begin bad++; $display("FAIL period_%0d: got %0d want 64", k, done_cyc - prev); end
      total++;
      if (last_busy != 34) begin bad++; $display("FAIL busy_duty_%0d: got %0d want 34", k, last_busy); end
      total++;
      if (last_data !== exp) begin bad++; $display("FAIL b2b_data_%0d: got %h want %h", k, last_data, exp); end
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    int cnt0, busy_cyc;
    logic [7:0] exp;
    addr_in = 8'h20;
    exp_q.push_back(model_sample(8'h20));
    for (int i = 0; i < 100 && busy !== 1'b1; i++) begin @(posedge m_clk); #1; end
    repeat (9) @(posedge m_clk);
    #1; en = 1'b0;
    addr_in = 8'hFF;
    wait_frame(ok);
    exp = exp_q.pop_front();
    total++;
    if (last_bits != 16) begin bad++; $display("FAIL en_drop_bits: got %0d want 16", last_bits); end
    total++;
    if (last_word !== {4'b0011, exp, 4'b0000}) begin
      bad++; $display("FAIL en_drop_word: got %h want %h", last_word, {4'b0011, exp, 4'b0000});
    end
    cnt0 = done_cnt; busy_cyc = 0;
    repeat (200) begin @(posedge m_clk); #1; if (busy !== 1'b0) busy_cyc++; end
    total++;
    if (busy_cyc != 0 || done_cnt != cnt0) begin
      bad++; $display("FAIL en_low_idle: got busy=%0d frames=%0d want 0 0", busy_cyc, done_cnt - cnt0);
    end
    total++;
    if (data_out !== exp) begin bad++; $display("FAIL data_hold: got %h want %h", data_out, exp); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] exp;
    en = 1'b1; addr_in = 8'h20;
    for (int i = 0; i < 100 && busy !== 1'b1; i++) begin @(posedge m_clk); #1; end
    repeat (19) @(posedge m_clk);
    #1; reset = 1'b1;
    @(posedge m_clk); #1;
    total++;
    if ({dac_sync_n, dac_sclk, busy, data_out, frame_done} !== 12'b1_0_0_0000_0000_0) begin
      bad++; $display("FAIL mid_reset: got %b want %b", {dac_sync_n, dac_sclk, busy, data_out, frame_done},
                      12'b1_0_0_0000_0000_0);
    end
    @(posedge m_clk); #1;
    addr_in = 8'h30;
    exp_q.push_back(model_sample(8'h30));
    reset = 1'b0;
    @(posedge m_clk); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL restart_capture: got %b want 1", busy); end
    wait_frame(ok);
    exp = exp_q.pop_front();
    total++;
    if (last_data !== exp || last_word !== {4'b0011, exp, 4'b0000}) begin
      bad++; $display("FAIL restart_frame: got %h/%h want %h/%h", last_data, last_word, exp, {4'b0011, exp, 4'b0000});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_table();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    total++;
    if (fd_wide != 0) begin bad++; $display("FAIL frame_done_width: got %0d long pulses want 0", fd_wide); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
